// File: rtl/bist_pkg.sv
// Shared constants and types for the BIST sequencing logic:
// FSM state encodings, default widths and the datapath LFSR seed.
package bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_CMP   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int SIG_W_DEFAULT    = 4;
   localparam int N_CYCLES_DEFAULT = 8;

   localparam logic [SIG_W_DEFAULT-1:0] LFSR_SEED = 4'b1001;

   // States in which a run is in flight and abort is honoured.
   function automatic logic is_active(input state_t s);
      return (s == ST_CLEAR) || (s == ST_RUN) || (s == ST_CMP);
   endfunction

endpackage

// File: rtl/bist_cycle_counter.sv
// Pattern-cycle counter for a BIST run: cleared in CLEAR, counts in RUN,
// flags terminal count at N_CYCLES-1 and never wraps.
module bist_cycle_counter #(
   parameter  int N_CYCLES = 8,
   localparam int CNT_W    = $clog2(N_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(N_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   assign tc = (cnt == TC_VAL);

   // Saturate at the terminal value so a stalled exit can never wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !tc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/bist_controller.sv
// BIST run sequencer: start edge -> clear, N_CYCLES enabled, signature compare, done/pass.
// Optional BIST_SIG_CAPTURE_EN adds sig_cap/sig_diff debug outputs.
module bist_controller
   import bist_pkg::*;
#(
   parameter int SIG_W    = SIG_W_DEFAULT,
   parameter int N_CYCLES = N_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [SIG_W-1:0] golden,
   input  logic [SIG_W-1:0] signature,
   output logic             bist_clr,
   output logic             bist_en,
   output logic             busy,
   output logic             done,
   output logic             pass
`ifdef BIST_SIG_CAPTURE_EN
   ,
   output logic [SIG_W-1:0] sig_cap,
   output logic [SIG_W-1:0] sig_diff
`endif
);

   state_t state;
   logic   start_q;
   logic   start_pulse;
   logic   tc;
   logic   cnt_clr;
   logic   cnt_en;

   assign start_pulse = start & ~start_q;
   assign cnt_clr     = (state == ST_CLEAR);
   assign cnt_en      = (state == ST_RUN);

   bist_cycle_counter #(
      .N_CYCLES (N_CYCLES)
   ) u_cycle_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .tc    (tc)
   );

   // Outputs are set on the same edge that enters a state, so each one
   // is valid for exactly the cycles the FSM spends in that state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         start_q  <= 1'b0;
         bist_clr <= 1'b0;
         bist_en  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
      end else begin
         start_q  <= start;
         bist_clr <= 1'b0;
         if (abort && is_active(state)) begin
            state   <= ST_IDLE;
            bist_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
         end else begin
            case (state)
               ST_IDLE, ST_DONE: begin
                  if (start_pulse) begin
                     state    <= ST_CLEAR;
                     bist_clr <= 1'b1;
                     busy     <= 1'b1;
                     done     <= 1'b0;
                     pass     <= 1'b0;
                  end
               end
               ST_CLEAR: begin
                  state   <= ST_RUN;
                  bist_en <= 1'b1;
               end
               ST_RUN: begin
                  if (tc) begin
                     state   <= ST_CMP;
                     bist_en <= 1'b0;
                  end
               end
               ST_CMP: begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (signature == golden);
               end
               default: begin
                  state   <= ST_IDLE;
                  bist_en <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b0;
                  pass    <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef BIST_SIG_CAPTURE_EN
   // Captured signature survives in DONE for debug and is wiped on the next run.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sig_cap  <= '0;
         sig_diff <= '0;
      end else if (state == ST_CLEAR) begin
         sig_cap  <= '0;
         sig_diff <= '0;
      end else if (state == ST_CMP && !abort) begin
         sig_cap  <= signature;
         sig_diff <= signature ^ golden;
      end
   end
`endif

endmodule
